// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit single-cycle core: fetch FSM states and
// basic architectural constants.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and instruction-fetch sequencer (IDLE -> REQ -> HOLD).
// Optional ack-timeout with sticky fetch_fault when PC_FETCH_TIMEOUT_EN is defined.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault
);

  // Handshake: imem_req stays high from entering REQ until the cycle imem_ack
  // is seen; data is taken in that same cycle and the request is never withdrawn.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  fetch_state_e state, state_next;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         timeout_hit;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wait_cnt;
  logic          fault_q;

  // The counter is held at zero outside REQ, so it is already clear on entry.
  assign timeout_hit = (state == REQ) && !imem_ack
                       && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != REQ) begin
      wait_cnt <= '0;
    end else if (!imem_ack && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (timeout_hit) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
    end else begin
      state <= state_next;
      case (state)
        REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
          end else if (timeout_hit) begin
            instr_q <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q <= redirect ? (next_pc & ALIGN_MASK) : pc_plus4;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (imem_ack || timeout_hit) state_next = HOLD;
      HOLD:    if (!stall) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  assign imem_req    = (state == REQ);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc_q & ALIGN_MASK;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(WORD_BYTES);
  assign instr       = instr_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the 32-bit single-cycle core.
- Consumes the 32-bit next-address value produced by the jump-address concatenation stage and owns the architectural PC.
- Issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched instruction, its PC and PC+4 to decode. PC+4 is fed back to the jump stage as its sequential input.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, ack wait limit; used only when the optional feature is enabled.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- next_pc  in  32  next-address value from the jump-address stage.
- redirect  in  1  1 = load next_pc as the new PC; 0 = sequential PC+4.
- stall  in  1  holds the current instruction; no new fetch is issued.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  32  word-aligned fetch address, bits[1:0] = 2'b00.
- imem_ack  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack = 1.
- pc  out  32  PC of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr and pc are valid for decode.
- fetch_fault  out  1  sticky timeout flag (feature only; tied 0 otherwise).

Behaviour:
- Reset: pc = RESET_VECTOR, instr = 32'h0000_0000, instr_valid = 0, imem_req = 0, fetch_fault = 0, state = IDLE.
  - rst dominates every other input.
  - rst mid-fetch abandons the request. A late imem_ack after reset is ignored because imem_req is 0.
- State machine:
  - IDLE: imem_req = 0. Next cycle -> REQ (one bubble after reset).
  - REQ: imem_req = 1, imem_addr = {pc[31:2], 2'b00}.
    - imem_ack = 1: latch instr = imem_rdata, set instr_valid = 1, -> HOLD.
    - Otherwise stay in REQ with the address stable.
  - HOLD: instr_valid = 1, imem_req = 0.
    - stall = 1: stay; pc, instr and instr_valid are frozen.
    - stall = 0: pc <= redirect ? {next_pc[31:2], 2'b00} : pc_plus4. Clear instr_valid, -> REQ.
- Latency: with zero-wait memory (ack in the first REQ cycle), one instruction every 2 cycles. Each cycle of ack delay adds one cycle.
- redirect and next_pc are sampled only in HOLD with stall = 0. They are ignored in IDLE and REQ, and while stalled.
- next_pc[1:0] are silently forced to 0.
- pc_plus4 is combinational from pc.
  - pc = 32'hFFFF_FFFC wraps: pc_plus4 = 32'h0000_0000.
  - Sequential advance from 32'hFFFF_FFFC therefore fetches address 0 with no flag.
- stall asserted while in REQ has no effect until HOLD; an outstanding request is never withdrawn.
- instr_valid is 0 in IDLE and REQ. Decode must treat instr as a bubble then.

Optional Feature:
- Macro: PC_FETCH_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES)+1) counts REQ cycles without ack, and clears on entering REQ.
  - Reaching TIMEOUT_CYCLES sets fetch_fault = 1 (sticky until rst) and moves to HOLD with instr = 32'h0000_0000 (NOP) and instr_valid = 1.
  - pc advances normally afterwards.
- Undefined: no counter; REQ waits indefinitely; fetch_fault tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum (IDLE, REQ, HOLD).
  - NOP_INSTR = 32'h0000_0000.
  - WORD_BYTES = 4.
  - XLEN = 32.
- No sub-module. The timeout counter, when enabled, stays inline as a generate/ifdef block.

Test Plan:
- Reset release, always-ack memory returning 32'h2008_0005 -> IDLE for 1 cycle; imem_addr = 0 on cycle 2; instr_valid = 1, pc = 0, pc_plus4 = 4 on cycle 3.
- Sequential run of 4 fetches, no redirect -> imem_addr sequence 0, 4, 8, C; one instr_valid every 2 cycles.
- In HOLD with redirect = 1 and next_pc = 32'h0040_0023 -> next imem_addr = 32'h0040_0020 and pc = 32'h0040_0020; redirect pulsed during REQ is ignored.
- stall held for 5 cycles in HOLD, with redirect toggling -> pc, instr and instr_valid unchanged and no imem_req; after release exactly one advance.
- Ack delayed 3 cycles, then rst pulsed during REQ -> imem_addr stable while waiting; after rst, pc = RESET_VECTOR, imem_req = 0, instr_valid = 0.
- PC_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES = 4, ack never asserted -> after 4 REQ cycles fetch_fault = 1, instr = 0, instr_valid = 1; pc = 32'hFFFF_FFFC sequential advance -> fetch address 0.
